// File: rtl/pwm_uart_reporter.sv
// Multi-channel PWM pulse-width meter: each captured width is reported as an
// ASCII line "<ch>:<hex>\r\n" over one shared 8N1 UART transmitter.
module pwm_uart_reporter #(
  parameter int NUM_CH        = 2,
  parameter int COUNTER_WIDTH = 24,
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int MEASURE_HIGH  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pwm_in_i,
  input  logic              enable_i,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic [NUM_CH-1:0] overflow_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int NIB          = COUNTER_WIDTH / 4;
  localparam int LINE_LEN     = NIB + 4;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W       = $clog2(LINE_LEN);
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic ACT        = (MEASURE_HIGH != 0);
  localparam logic [COUNTER_WIDTH-1:0] SAT = '1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h37 + {4'd0, nib});
  endfunction

  logic [NUM_CH-1:0]        sync_p0, sync_p1, act_p2, seen, pend;
  logic [NUM_CH-1:0]        act, entry, cap_fire, load_ch;
  logic [COUNTER_WIDTH-1:0] cnt     [NUM_CH];
  logic [COUNTER_WIDTH-1:0] cap_val [NUM_CH];
  logic [COUNTER_WIDTH-1:0] load_val;
  logic [CH_W-1:0]          last_ch, sel_ch, idx;
  logic                     sel_vld, load, baud_done;
  state_t                   state;
  logic [BAUD_W-1:0]        baud;
  logic [2:0]               bit_idx;
  logic [BYTE_W-1:0]        byte_idx;
  logic [7:0]               line_buf [LINE_LEN];

  assign act      = ACT ? sync_p1 : ~sync_p1;
  assign entry    = act & ~act_p2;
  assign cap_fire = ~act & act_p2 & seen & {NUM_CH{enable_i}};

  // Stage p0/p1: synchroniser; p2: previous active level for edge detection.
  // Synchronisers start at the active level so a pin idling at reset release
  // looks like an exit, which is ignored until a real entry has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0    <= {NUM_CH{ACT}};
      sync_p1    <= {NUM_CH{ACT}};
      act_p2     <= '1;
      seen       <= '0;
      pend       <= '0;
      overflow_o <= '0;
      for (int n = 0; n < NUM_CH; n++) cnt[n] <= '0;
    end else begin
      sync_p0 <= pwm_in_i;
      sync_p1 <= sync_p0;
      act_p2  <= act;
      for (int n = 0; n < NUM_CH; n++) begin
        if (entry[n]) begin
          cnt[n]  <= COUNTER_WIDTH'(1);
          seen[n] <= 1'b1;
        end else if (act[n] && seen[n] && cnt[n] != SAT) begin
          cnt[n] <= cnt[n] + COUNTER_WIDTH'(1);
          if (cnt[n] == SAT - COUNTER_WIDTH'(1)) overflow_o[n] <= 1'b1;
        end
        // A same-cycle load still sends the old value, so nothing is lost there.
        if (cap_fire[n]) begin
          pend[n] <= 1'b1;
          if (pend[n] && !load_ch[n]) overflow_o[n] <= 1'b1;
        end else if (load_ch[n]) begin
          pend[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++)
      if (cap_fire[n]) cap_val[n] <= cnt[n];
  end

  // Round-robin: the lowest offset after the last served channel wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_ch  = '0;
    idx     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = CH_W'((int'(last_ch) + i) % NUM_CH);
      if (pend[idx]) begin
        sel_vld = 1'b1;
        sel_ch  = idx;
      end
    end
  end

  assign load     = (state == IDLE) && sel_vld;
  assign load_val = cap_val[sel_ch];

  always_comb begin
    load_ch = '0;
    if (load) load_ch[sel_ch] = 1'b1;
  end

  // Line buffer: the whole ASCII line is encoded in the load cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      line_buf[0] <= 8'h30 + 8'(sel_ch);
      line_buf[1] <= 8'h3A;
      for (int k = 0; k < NIB; k++)
        line_buf[2+k] <= hex_char(load_val[COUNTER_WIDTH-1-4*k -: 4]);
      line_buf[LINE_LEN-2] <= 8'h0D;
      line_buf[LINE_LEN-1] <= 8'h0A;
    end
  end

  assign baud_done = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  // Serializer: tx is registered from the state, so it trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      last_ch   <= CH_W'(NUM_CH - 1);
      uart_tx_o <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      busy_o <= (state != IDLE) || load;
      case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          if (load) begin
            state    <= START;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            last_ch  <= sel_ch;
          end
        end
        START: begin
          uart_tx_o <= 1'b0;
          if (baud_done) begin
            state <= DATA;
            baud  <= '0;
          end else baud <= baud + BAUD_W'(1);
        end
        DATA: begin
          uart_tx_o <= line_buf[byte_idx][bit_idx];
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
            end else bit_idx <= bit_idx + 3'd1;
          end else baud <= baud + BAUD_W'(1);
        end
        STOP: begin
          uart_tx_o <= 1'b1;
          if (baud_done) begin
            baud <= '0;
            if (byte_idx == BYTE_W'(LINE_LEN - 1)) begin
              state    <= IDLE;
              byte_idx <= '0;
            end else begin
              state    <= START;
              byte_idx <= byte_idx + BYTE_W'(1);
            end
          end else baud <= baud + BAUD_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_uart_reporter.sv
// Bench for pwm_uart_reporter: a low-phase 2-channel 8-bit instance and a
// high-phase 1-channel 24-bit instance, each with a UART decoder feeding a scoreboard.
module tb_pwm_uart_reporter;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] pwm = 2'b11;
  logic [0:0] pwm_hi = 1'b0;
  logic       tx, busy, tx_hi, busy_hi;
  logic [1:0] ovf;
  logic [0:0] ovf_hi;
  logic [8:0] mon_lo, mon_hi;
  int n_cmp = 0, n_fail = 0;
  int exp_q[$], rx_q[$], exp_hi_q[$], rx_hi_q[$];

  always #5 clk = ~clk;

  pwm_uart_reporter #(.NUM_CH(2), .COUNTER_WIDTH(8), .CLK_FREQ_HZ(1_000_000),
                      .BAUD_RATE(100_000), .MEASURE_HIGH(0)) u_dut (
    .clk(clk), .reset(reset), .pwm_in_i(pwm), .enable_i(enable),
    .uart_tx_o(tx), .busy_o(busy), .overflow_o(ovf));

  pwm_uart_reporter #(.NUM_CH(1), .COUNTER_WIDTH(24), .CLK_FREQ_HZ(1_000_000),
                      .BAUD_RATE(100_000), .MEASURE_HIGH(1)) u_hi (
    .clk(clk), .reset(reset), .pwm_in_i(pwm_hi), .enable_i(enable),
    .uart_tx_o(tx_hi), .busy_o(busy_hi), .overflow_o(ovf_hi));

  // UART decoders: bit 8 of a pushed value flags a bad start or stop bit.
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        mon_lo = '0;
        repeat (CPB/2 - 1) @(negedge clk);
        if (tx !== 1'b0) mon_lo[8] = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_lo[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) mon_lo[8] = 1'b1;
        rx_q.push_back(int'(mon_lo));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_hi === 1'b0) begin
        mon_hi = '0;
        repeat (CPB/2 - 1) @(negedge clk);
        if (tx_hi !== 1'b0) mon_hi[8] = 1'b1;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          mon_hi[j] = tx_hi;
        end
        repeat (CPB) @(negedge clk);
        if (tx_hi !== 1'b1) mon_hi[8] = 1'b1;
        rx_hi_q.push_back(int'(mon_hi));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_line(input bit hi, input int ch, input int val, input int nib);
    int d;
    int b[$];
    b.push_back(48 + ch);
    b.push_back(58);
    for (int k = nib - 1; k >= 0; k--) begin
      d = (val >> (4 * k)) & 15;
      b.push_back((d < 10) ? (48 + d) : (55 + d));
    end
    b.push_back(13);
    b.push_back(10);
    foreach (b[m]) begin
      if (hi) exp_hi_q.push_back(b[m]);
      else exp_q.push_back(b[m]);
    end
  endtask

  task automatic pulse(input logic [1:0] mask, input int n);
    @(posedge clk); #1;
    pwm = pwm & ~mask;
    repeat (n) @(posedge clk);
    #1 pwm = pwm | mask;
  endtask

  task automatic wait_rx(input bit hi, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if ((hi ? rx_hi_q.size() : rx_q.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (busy === lvl) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b want 00", ovf); end
    n_cmp++; if (tx_hi !== 1'b1 || busy_hi !== 1'b0 || ovf_hi !== 1'b0) begin
      n_fail++; $display("FAIL reset_hi: got tx=%b busy=%b ovf=%b want 1 0 0", tx_hi, busy_hi, ovf_hi);
    end
    repeat (60) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL reset_quiet: got busy=%b bytes=%0d want 0 0", busy, rx_q.size());
    end
  endtask

  task automatic test_line_timing();
    int bc, lr, e, r;
    bit first_run;
    logic t2;
    push_line(0, 0, 26, 2);
    pulse(2'b01, 26);
    wait_busy(1'b1, 100);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timing_busy_rise: got %b want 1", busy); end
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL timing_tx_at_load: got %b want 1", tx); end
    bc = 1; lr = 0; first_run = 1'b1; t2 = 1'bx;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      bc++;
      if (bc == 2) t2 = tx;
      if (first_run) begin
        if (tx === 1'b0) lr++;
        else if (lr > 0) first_run = 1'b0;
      end
    end
    n_cmp++; if (t2 !== 1'b0) begin n_fail++; $display("FAIL timing_start_latency: got %b want 0", t2); end
    n_cmp++; if (bc != 601) begin n_fail++; $display("FAIL timing_busy_len: got %0d want 601", bc); end
    n_cmp++; if (lr != 50) begin n_fail++; $display("FAIL timing_first_low_run: got %0d want 50", lr); end
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL timing_idle_tx: got %b want 1", tx); end
    wait_rx(0, 6, 200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL timing_byte: got none want %02h", e); end
      else begin
        r = rx_q.pop_front();
        if (r !== e) begin n_fail++; $display("FAIL timing_byte: got %03h want %02h", r, e); end
      end
    end
    n_cmp++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL timing_ovf: got %b want 00", ovf); end
  endtask

  task automatic test_saturation();
    int e, r;
    wait_busy(1'b0, 2000);
    push_line(0, 0, 255, 2);
    pulse(2'b01, 300);
    wait_rx(0, 6, 1000);
    wait_busy(1'b0, 200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL sat_byte: got none want %02h", e); end
      else begin
        r = rx_q.pop_front();
        if (r !== e) begin n_fail++; $display("FAIL sat_byte: got %03h want %02h", r, e); end
      end
    end
    n_cmp++; if (ovf !== 2'b01) begin n_fail++; $display("FAIL sat_ovf: got %b want 01", ovf); end
  endtask

  task automatic test_round_robin();
    int e, r;
    wait_busy(1'b0, 2000);
    do_reset();
    push_line(0, 0, 5, 2);
    push_line(0, 1, 7, 2);
    @(posedge clk); #1 pwm = 2'b01;
    repeat (2) @(posedge clk); #1 pwm = 2'b00;
    repeat (5) @(posedge clk); #1 pwm = 2'b11;
    wait_rx(0, 12, 1500);
    wait_busy(1'b0, 200);
    n_cmp++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL rr_ovf_clean: got %b want 00", ovf); end
    push_line(0, 0, 2, 2);
    push_line(0, 1, 3, 2);
    pulse(2'b01, 2);
    wait_busy(1'b1, 100);
    pulse(2'b10, 9);
    repeat (5) @(posedge clk);
    pulse(2'b10, 3);
    wait_rx(0, 24, 1500);
    wait_busy(1'b0, 200);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL rr_byte: got none want %02h", e); end
      else begin
        r = rx_q.pop_front();
        if (r !== e) begin n_fail++; $display("FAIL rr_byte: got %03h want %02h", r, e); end
      end
    end
    n_cmp++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL rr_ovf_overwrite: got %b want 10", ovf); end
  endtask

  task automatic test_enable();
    int e, r;
    wait_busy(1'b0, 2000);
    @(posedge clk); #1 enable = 1'b0;
    pulse(2'b01, 10);
    repeat (6) @(posedge clk);
    #1 enable = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL enable_ignored: got busy=%b bytes=%0d want 0 0", busy, rx_q.size());
    end
    push_line(0, 1, 44, 2);
    pulse(2'b10, 44);
    wait_busy(1'b1, 100);
    repeat (250) @(posedge clk);
    #1 enable = 1'b0;
    wait_rx(0, 6, 1000);
    wait_busy(1'b0, 200);
    @(posedge clk); #1 enable = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL enable_byte: got none want %02h", e); end
      else begin
        r = rx_q.pop_front();
        if (r !== e) begin n_fail++; $display("FAIL enable_byte: got %03h want %02h", r, e); end
      end
    end
    n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL enable_extra: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_reset_mid();
    int e, r;
    wait_busy(1'b0, 2000);
    pulse(2'b01, 59);
    wait_busy(1'b1, 100);
    repeat (250) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_cmp++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL midreset_ovf: got %b want 00", ovf); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (150) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    push_line(0, 0, 4, 2);
    pulse(2'b01, 4);
    wait_rx(0, 6, 1000);
    wait_busy(1'b0, 200);
    repeat (50) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_fail++; $display("FAIL midreset_byte: got none want %02h", e); end
      else begin
        r = rx_q.pop_front();
        if (r !== e) begin n_fail++; $display("FAIL midreset_byte: got %03h want %02h", r, e); end
      end
    end
    n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL midreset_remnant: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_measure_high();
    int e, r;
    push_line(1, 0, 'hABCD, 6);
    @(posedge clk); #1 pwm_hi = 1'b1;
    repeat ('hABCD) @(posedge clk);
    #1 pwm_hi = 1'b0;
    wait_rx(1, 10, 1500);
    while (exp_hi_q.size() > 0) begin
      e = exp_hi_q.pop_front(); n_cmp++;
      if (rx_hi_q.size() == 0) begin n_fail++; $display("FAIL high_byte: got none want %02h", e); end
      else begin
        r = rx_hi_q.pop_front();
        if (r !== e) begin n_fail++; $display("FAIL high_byte: got %03h want %02h", r, e); end
      end
    end
    n_cmp++; if (ovf_hi !== 1'b0) begin n_fail++; $display("FAIL high_ovf: got %b want 0", ovf_hi); end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_saturation();
    test_round_robin();
    test_enable();
    test_reset_mid();
    test_measure_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
